// File: rtl/bram_rr_arbiter_if.sv
// Two-port requester bus and BRAM-side signals of the round-robin BRAM arbiter.
// slave = arbiter side, master = requesters plus memory.
interface bram_rr_arbiter_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic                  req0;
    logic                  req1;
    logic                  we0;
    logic                  we1;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] wdata0;
    logic [DATA_WIDTH-1:0] wdata1;
    logic                  gnt0;
    logic                  gnt1;
    logic                  rvalid0;
    logic                  rvalid1;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic [DATA_WIDTH-1:0] mem_dout;
    logic [3:0]            rd_inflight;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata,
               mem_en, mem_we, mem_addr, mem_din, rd_inflight
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata,
               mem_en, mem_we, mem_addr, mem_din, rd_inflight
    );
endinterface

// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters, with
// fully pipelined reads tagged back to their owner after READ_LATENCY cycles.
module bram_rr_arbiter #(
    parameter int ADDR_WIDTH   = 15,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 3
) (
    input  logic             clk_a,
    input  logic             arstz_aq,
    bram_rr_arbiter_if.slave bus
);
    logic                  w_gnt0;
    logic                  w_gnt1;
    logic                  w_any_gnt;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic                  w_rd_issue;
    logic                  w_rd_return;

    logic                  r_ptr;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic                  r_mem_port;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;
    logic                  r_tag_valid [READ_LATENCY];
    logic                  r_tag_port  [READ_LATENCY];
    logic [3:0]            r_rd_inflight;

    // Grants are gated by reset so nothing is accepted while the block is held.
    always_comb begin
        w_gnt0      = arstz_aq & bus.req0 & (~bus.req1 | ~r_ptr);
        w_gnt1      = arstz_aq & bus.req1 & (~bus.req0 | r_ptr);
        w_any_gnt   = w_gnt0 | w_gnt1;
        w_sel_we    = w_gnt1 ? bus.we1    : bus.we0;
        w_sel_addr  = w_gnt1 ? bus.addr1  : bus.addr0;
        w_sel_wdata = w_gnt1 ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            r_ptr      <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_port <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
        end else begin
            if (w_gnt0) begin
                r_ptr <= 1'b1;
            end else if (w_gnt1) begin
                r_ptr <= 1'b0;
            end
            r_mem_en <= w_any_gnt;
            r_mem_we <= w_any_gnt & w_sel_we;
            if (w_any_gnt) begin
                r_mem_port <= w_gnt1;
                r_mem_addr <= w_sel_addr;
                r_mem_din  <= w_sel_wdata;
            end
        end
    end

    assign w_rd_issue  = r_mem_en & ~r_mem_we;
    assign w_rd_return = r_tag_valid[READ_LATENCY-1];

    // Owner tags travel alongside the BRAM read pipeline; the last stage lines up with mem_dout.
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_tag
        always_ff @(posedge clk_a or negedge arstz_aq) begin
            if (!arstz_aq) begin
                r_tag_valid[gi] <= 1'b0;
                r_tag_port[gi]  <= 1'b0;
            end else begin
                if (gi == 0) begin
                    r_tag_valid[gi] <= w_rd_issue;
                    r_tag_port[gi]  <= r_mem_port;
                end else begin
                    r_tag_valid[gi] <= r_tag_valid[(gi == 0) ? 0 : gi-1];
                    r_tag_port[gi]  <= r_tag_port[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    end

    always_ff @(posedge clk_a or negedge arstz_aq) begin
        if (!arstz_aq) begin
            r_rd_inflight <= 4'd0;
        end else begin
            case ({w_rd_issue, w_rd_return})
                2'b10:   r_rd_inflight <= r_rd_inflight + 4'd1;
                2'b01:   r_rd_inflight <= r_rd_inflight - 4'd1;
                default: r_rd_inflight <= r_rd_inflight;
            endcase
        end
    end

    assign bus.gnt0        = w_gnt0;
    assign bus.gnt1        = w_gnt1;
    assign bus.rvalid0     = r_tag_valid[READ_LATENCY-1] & ~r_tag_port[READ_LATENCY-1];
    assign bus.rvalid1     = r_tag_valid[READ_LATENCY-1] &  r_tag_port[READ_LATENCY-1];
    assign bus.rdata       = bus.mem_dout;
    assign bus.mem_en      = r_mem_en;
    assign bus.mem_we      = r_mem_we;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.mem_din     = r_mem_din;
    assign bus.rd_inflight = r_rd_inflight;
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter: directed vectors, corner sequences, latency sweep
// on extra instances, and random traffic against a transaction-level model.
module tb_bram_rr_arbiter;
    localparam int AW = 15;
    localparam int DW = 32;
    localparam int RL = 3;

    logic clk_a    = 1'b0;
    logic arstz_aq = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    always #5 clk_a = ~clk_a;

    bram_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
    bram_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
    bram_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus8 ();

    bram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) u_dut (
        .clk_a(clk_a), .arstz_aq(arstz_aq), .bus(bus));
    bram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut_l1 (
        .clk_a(clk_a), .arstz_aq(arstz_aq), .bus(bus1));
    bram_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(8)) u_dut_l8 (
        .clk_a(clk_a), .arstz_aq(arstz_aq), .bus(bus8));

    function automatic logic [DW-1:0] pat(input int a);
        return 32'h3C5A_0000 ^ (32'(a) * 32'h0001_0101);
    endfunction

    // Memory behind the main instance: synchronous write, READ_LATENCY-cycle read.
    logic [DW-1:0] bram [0:(1<<AW)-1];
    logic [DW-1:0] pipe [0:RL-1];
    always @(posedge clk_a) begin
        if (bus.mem_en && bus.mem_we) bram[bus.mem_addr] <= bus.mem_din;
        pipe[0] <= bram[bus.mem_addr];
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_dout = pipe[RL-1];

    // Sweep instances see only port-0 traffic and a read-only pattern memory.
    logic [DW-1:0] p1;
    logic [DW-1:0] p8 [0:7];
    always @(posedge clk_a) begin
        p1    <= pat(int'(bus1.mem_addr));
        p8[0] <= pat(int'(bus8.mem_addr));
        for (int i = 1; i < 8; i++) p8[i] <= p8[i-1];
    end
    assign bus1.mem_dout = p1;
    assign bus8.mem_dout = p8[7];

    assign bus1.req0 = bus.req0;  assign bus1.we0 = bus.we0;
    assign bus1.addr0 = bus.addr0; assign bus1.wdata0 = bus.wdata0;
    assign bus1.req1 = 1'b0;      assign bus1.we1 = 1'b0;
    assign bus1.addr1 = '0;       assign bus1.wdata1 = '0;
    assign bus8.req0 = bus.req0;  assign bus8.we0 = bus.we0;
    assign bus8.addr0 = bus.addr0; assign bus8.wdata0 = bus.wdata0;
    assign bus8.req1 = 1'b0;      assign bus8.we1 = 1'b0;
    assign bus8.addr1 = '0;       assign bus8.wdata1 = '0;

    // Reference model state: arbitration pointer, memory image in grant order,
    // outstanding reads with the cycle their data is due, and last cycle's grant.
    typedef struct {
        int            due;
        int            issue;
        bit            port;
        logic [DW-1:0] data;
    } rd_t;
    typedef struct {
        bit            valid;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    int            ref_ptr = 0;
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    rd_t           pend [$];
    op_t           exp_op;
    bit            last_g0, last_g1;

    typedef struct {
        bit            r0, r1;
        logic [AW-1:0] a0, a1;
        bit            g0, g1;
    } vec_t;
    vec_t vec [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle: compare every output with the model, advance the model, cross the edge.
    task automatic tick();
        bit            eg0, eg1, ev0, ev1, p;
        logic [DW-1:0] ed;
        int            n_inf;
        rd_t           e;
        #1;
        eg0 = 0; eg1 = 0; ev0 = 0; ev1 = 0; ed = '0; n_inf = 0;
        if (arstz_aq) begin
            eg0 = bus.req0 && (!bus.req1 || ref_ptr == 0);
            eg1 = bus.req1 && !eg0;
            foreach (pend[i]) begin
                if (pend[i].due == cyc) begin
                    if (pend[i].port) ev1 = 1; else ev0 = 1;
                    ed = pend[i].data;
                end
                if (pend[i].issue < cyc && pend[i].due >= cyc) n_inf++;
            end
        end
        chk("gnt0", bus.gnt0, eg0);
        chk("gnt1", bus.gnt1, eg1);
        chk("mem_en", bus.mem_en, arstz_aq && exp_op.valid);
        chk("mem_we", bus.mem_we, arstz_aq && exp_op.valid && exp_op.we);
        if (arstz_aq && exp_op.valid) begin
            chk("mem_addr", bus.mem_addr, exp_op.addr);
            chk("mem_din", bus.mem_din, exp_op.din);
        end
        chk("rvalid0", bus.rvalid0, ev0);
        chk("rvalid1", bus.rvalid1, ev1);
        if (ev0 || ev1) chk("rdata", bus.rdata, ed);
        chk("rd_inflight", bus.rd_inflight, n_inf);
        last_g0 = eg0;
        last_g1 = eg1;
        if (!arstz_aq) begin
            pend.delete();
            ref_ptr = 0;
            exp_op.valid = 0;
        end else begin
            for (int i = pend.size() - 1; i >= 0; i--)
                if (pend[i].due <= cyc) pend.delete(i);
            exp_op.valid = eg0 || eg1;
            if (exp_op.valid) begin
                p           = eg1;
                exp_op.we   = p ? bus.we1 : bus.we0;
                exp_op.addr = p ? bus.addr1 : bus.addr0;
                exp_op.din  = p ? bus.wdata1 : bus.wdata0;
                if (exp_op.we) begin
                    ref_mem[exp_op.addr] = exp_op.din;
                end else begin
                    e.due = cyc + 1 + RL; e.issue = cyc + 1; e.port = p; e.data = ref_mem[exp_op.addr];
                    pend.push_back(e);
                end
                ref_ptr = eg0 ? 1 : 0;
                $display("txn cyc=%0d port=%0d %s addr=0x%0h data=0x%0h", cyc, p,
                         exp_op.we ? "WR" : "RD", exp_op.addr,
                         exp_op.we ? exp_op.din : ref_mem[exp_op.addr]);
            end
        end
        @(posedge clk_a);
        cyc++;
        @(negedge clk_a);
    endtask

    task automatic idle(input int n);
        bus.req0 = 0; bus.req1 = 0;
        repeat (n) tick();
    endtask

    initial begin
        int            en_cnt, s3, s1, s8, rv1_cnt, max_inf, rv_cnt, first_rv, last_rv;
        logic [DW-1:0] d3, d1, d8;
        bit            act0, act1;

        for (int i = 0; i < (1 << AW); i++) begin
            bram[i]    = pat(i);
            ref_mem[i] = pat(i);
        end
        for (int i = 0; i < RL; i++) pipe[i] = '0;
        exp_op = '{valid: 1'b0, we: 1'b0, addr: '0, din: '0};
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;

        // Reset: outputs held at zero even with both requests raised.
        @(posedge clk_a);
        @(negedge clk_a);
        bus.req0 = 1; bus.req1 = 1;
        #1;
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_din", bus.mem_din, 0);
        chk("rst_gnt0", bus.gnt0, 0);
        tick();
        arstz_aq = 1;

        // Arbitration vectors from release onward (pointer starts at 0).
        vec[0]  = '{1, 1, 15'h100, 15'h200, 1, 0};
        vec[1]  = '{1, 1, 15'h101, 15'h201, 0, 1};
        vec[2]  = '{1, 1, 15'h102, 15'h202, 1, 0};
        vec[3]  = '{1, 1, 15'h103, 15'h203, 0, 1};
        vec[4]  = '{0, 0, 15'h104, 15'h204, 0, 0};
        vec[5]  = '{0, 1, 15'h105, 15'h205, 0, 1};
        vec[6]  = '{1, 1, 15'h106, 15'h206, 1, 0};
        vec[7]  = '{1, 0, 15'h107, 15'h207, 1, 0};
        vec[8]  = '{1, 1, 15'h108, 15'h208, 0, 1};
        vec[9]  = '{0, 0, 15'h109, 15'h209, 0, 0};
        vec[10] = '{1, 1, 15'h10A, 15'h20A, 1, 0};
        en_cnt = 0;
        for (int i = 0; i < 11; i++) begin
            bus.req0 = vec[i].r0; bus.req1 = vec[i].r1;
            bus.we0 = 0; bus.we1 = 0;
            bus.addr0 = vec[i].a0; bus.addr1 = vec[i].a1;
            #1;
            chk($sformatf("vec%0d_gnt0", i), bus.gnt0, vec[i].g0);
            chk($sformatf("vec%0d_gnt1", i), bus.gnt1, vec[i].g1);
            tick();
            if (i < 4 && bus.mem_en) en_cnt++;
        end
        chk("contention_en4", en_cnt, 4);
        idle(12);

        // Single read at 0x10 on all three latencies.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 15'h10;
        tick();
        bus.req0 = 0;
        chk("single_mem_en", bus.mem_en, 1);
        chk("single_mem_addr", bus.mem_addr, 15'h10);
        s3 = -1; s1 = -1; s8 = -1; d3 = '0; d1 = '0; d8 = '0;
        for (int j = 1; j <= 12; j++) begin
            tick();
            if (bus.rvalid0  && s3 < 0) begin s3 = j; d3 = bus.rdata;  end
            if (bus1.rvalid0 && s1 < 0) begin s1 = j; d1 = bus1.rdata; end
            if (bus8.rvalid0 && s8 < 0) begin s8 = j; d8 = bus8.rdata; end
        end
        chk("lat3_cycle", s3, 3);
        chk("lat3_data", d3, pat(16));
        chk("lat1_cycle", s1, 1);
        chk("lat1_data", d1, pat(16));
        chk("lat8_cycle", s8, 8);
        chk("lat8_data", d8, pat(16));

        // Port 1 writes 0xCAFE to 0x5, port 0 reads it back the next cycle.
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 15'h5; bus.wdata1 = 32'hCAFE;
        tick();
        bus.req1 = 0;
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 15'h5;
        rv1_cnt = 0; d3 = '0; s3 = -1;
        tick();
        bus.req0 = 0;
        for (int j = 0; j < 8; j++) begin
            tick();
            if (bus.rvalid1) rv1_cnt++;
            if (bus.rvalid0 && s3 < 0) begin s3 = j; d3 = bus.rdata; end
        end
        chk("wr_rd_data", d3, 32'hCAFE);
        chk("wr_rd_no_rvalid1", rv1_cnt, 0);

        // Three back-to-back reads from port 0.
        max_inf = 0; rv_cnt = 0; first_rv = -1; last_rv = -1;
        for (int j = 0; j < 14; j++) begin
            bus.req0 = (j < 3); bus.we0 = 0; bus.addr0 = 15'(32'h20 + j);
            tick();
            if (int'(bus.rd_inflight) > max_inf) max_inf = int'(bus.rd_inflight);
            if (bus.rvalid0) begin
                rv_cnt++;
                if (first_rv < 0) first_rv = j;
                last_rv = j;
            end
        end
        chk("b2b_max_inflight", max_inf, 3);
        chk("b2b_rvalid_count", rv_cnt, 3);
        chk("b2b_rvalid_span", last_rv - first_rv, 2);
        chk("b2b_inflight_zero", bus.rd_inflight, 0);

        // Reset one cycle after two reads issue: everything clears, nothing returns.
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 15'h30;
        tick();
        bus.addr0 = 15'h31;
        tick();
        bus.req0 = 0;
        tick();
        chk("pre_rst_inflight", bus.rd_inflight, 2);
        arstz_aq = 0;
        #1;
        chk("mid_rst_mem_en", bus.mem_en, 0);
        chk("mid_rst_mem_addr", bus.mem_addr, 0);
        chk("mid_rst_mem_din", bus.mem_din, 0);
        chk("mid_rst_inflight", bus.rd_inflight, 0);
        tick();
        tick();
        arstz_aq = 1;
        rv_cnt = 0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (bus.rvalid0 || bus.rvalid1) rv_cnt++;
        end
        chk("post_rst_no_rvalid", rv_cnt, 0);

        // Random traffic: requests held until granted, occasionally dropped.
        act0 = 0; act1 = 0;
        for (int c = 0; c < 400; c++) begin
            if (!act0 && $urandom_range(0, 99) < 60) begin
                act0 = 1; bus.we0 = 1'($urandom_range(0, 1));
                bus.addr0 = 15'($urandom_range(0, 15)); bus.wdata0 = $urandom;
            end else if (act0 && $urandom_range(0, 99) < 3) begin
                act0 = 0;
            end
            if (!act1 && $urandom_range(0, 99) < 60) begin
                act1 = 1; bus.we1 = 1'($urandom_range(0, 1));
                bus.addr1 = 15'($urandom_range(0, 15)); bus.wdata1 = $urandom;
            end else if (act1 && $urandom_range(0, 99) < 3) begin
                act1 = 0;
            end
            bus.req0 = act0; bus.req1 = act1;
            tick();
            if (last_g0) act0 = 0;
            if (last_g1) act1 = 0;
        end
        idle(RL + 4);
        chk("final_inflight", bus.rd_inflight, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/bram_rr_arbiter.md
BRAM_RR_ARBITER -- requirements
Module: bram_rr_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 15: memory address width.
REQ-002 SHALL provide parameter DATA_WIDTH, default 32: data width.
REQ-003 SHALL provide parameter READ_LATENCY, default 3, legal range 1..8: cycles from mem_en (read) to valid mem_dout.
REQ-004 clk_a  input  1  clock; all logic on rising edge.
REQ-005 arstz_aq  input  1  reset, asynchronous, active-low.
REQ-006 req0, req1  input  1 each  port n access request; held until granted.
REQ-007 we0, we1  input  1 each  port n write (1) / read (0); stable while reqn high.
REQ-008 addr0, addr1  input  ADDR_WIDTH each  port n address; stable while reqn high.
REQ-009 wdata0, wdata1  input  DATA_WIDTH each  port n write data; stable while reqn high.
REQ-010 gnt0, gnt1  output  1 each  combinational; request accepted this cycle.
REQ-011 rvalid0, rvalid1  output  1 each  registered; read data for port n present this cycle.
REQ-012 rdata  output  DATA_WIDTH  read data, shared by both ports; qualified by rvalid0/rvalid1.
REQ-013 mem_en, mem_we  output  1 each  registered BRAM enable and write enable.
REQ-014 mem_addr  output  ADDR_WIDTH  registered BRAM address.
REQ-015 mem_din  output  DATA_WIDTH  registered BRAM write data.
REQ-016 mem_dout  input  DATA_WIDTH  BRAM read data.
REQ-017 rd_inflight  output  4  count of reads issued whose data has not yet returned.

Function
REQ-018 SHALL accept at most one request per cycle; gnt0 and gnt1 are never high together.
REQ-019 If only one reqn is high, that port SHALL be granted in the same cycle.
REQ-020 If both are high, the port SHALL be chosen by a round-robin pointer: port 0 wins when the pointer is 0, port 1 wins when it is 1.
REQ-021 The pointer SHALL update only on a grant, to the non-granted port (granted 0 -> pointer 1, granted 1 -> pointer 0).
REQ-022 A request accepted in cycle T SHALL drive mem_en=1, mem_we=wen, mem_addr=addrn, mem_din=wdatan in cycle T+1; with no grant in T, mem_en=0 and mem_we=0 in T+1.
REQ-023 Reads SHALL be fully pipelined (back-to-back issue, no bubbles); rvalidn SHALL be high exactly in cycle T+1+READ_LATENCY with rdata=mem_dout.
REQ-024 Returned reads SHALL be tagged with their owner by a READ_LATENCY-deep shift register of {valid, port}; writes produce no rvalid.
REQ-025 rdata SHALL pass through mem_dout combinationally; its value is don't-care when neither rvalid is high.
REQ-026 rd_inflight SHALL increment on a read issue (mem_en & !mem_we) and decrement on an rvalid; if both occur in the same cycle it SHALL stay unchanged. Maximum value is READ_LATENCY, so it never wraps.
REQ-027 Writes and reads SHALL execute in grant order; a write granted before a read to the same address SHALL be visible to that read.
REQ-028 Requests that are deasserted without a grant SHALL be dropped silently.

Reset
REQ-029 While arstz_aq=0: gnt0=gnt1=0, and mem_en, mem_we, rvalid0, rvalid1, rd_inflight, the pointer and all tag stages SHALL be 0; mem_addr and mem_din SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight tags; no rvalid SHALL occur for reads issued before reset.
REQ-031 Release of reset SHALL take effect on the first clk_a edge after deassertion; a grant is possible in that cycle.

Verification
REQ-032 Single read, READ_LATENCY=3: req0=1, we0=0, addr0=0x10 at T -> gnt0 at T, mem_en=1/mem_addr=0x10 at T+1, rvalid0=1 at T+4 with rdata equal to the memory contents.
REQ-033 Contention: req0 and req1 both held high from reset for 4 cycles -> grants alternate 0,1,0,1; mem_en high in 4 consecutive cycles.
REQ-034 Write-then-read: port 1 writes 0xCAFE to 0x5, then port 0 reads 0x5 in the next cycle -> rvalid0 with rdata=0xCAFE; rvalid1 is never asserted.
REQ-035 Back-to-back reads: port 0 issues 3 reads in consecutive cycles -> rd_inflight reaches 3 and holds while issue and return overlap; 3 consecutive rvalid0 pulses; rd_inflight returns to 0.
REQ-036 Reset mid-flight: assert arstz_aq=0 one cycle after 2 reads are issued -> all outputs 0 immediately; no rvalid after release.
REQ-037 Latency sweep: repeat REQ-032 with READ_LATENCY=1 and 8 -> rvalid at T+2 and T+9 respectively.
